// File: rtl/puf_soc_pkg.sv
// Shared sequencer state encoding, default frame geometry and frame-length
// select helper for the arbiter-PUF SoC.
package puf_soc_pkg;

    localparam int unsigned DEF_REG_BIT_SIZE = 8;
    localparam int unsigned DEF_NORM_MOD     = 34;
    localparam int unsigned DEF_DEBUG_MOD    = 133;
    localparam int unsigned DEF_CNT_BIT_SIZE = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_CHAL,
        ST_LAUNCH,
        ST_WAIT,
        ST_TX
    } puf_seq_state_e;

    function automatic int unsigned frame_len(input logic        op_mode,
                                              input int unsigned norm_len,
                                              input int unsigned dbg_len);
        return op_mode ? dbg_len : norm_len;
    endfunction

endpackage

// File: rtl/puf_seq_piso.sv
// Loadable LSB-first parallel-in/serial-out shifter with a valid/ready
// handshake and a sent-bit counter; flags the handshake of the len-th bit.
module puf_seq_piso #(
    parameter int unsigned WIDTH = 133,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] len,
    input  logic             en,
    input  logic             ready,
    output logic             data,
    output logic             last
);

    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             hs;

    assign hs   = en && ready;
    assign last = hs && (cnt == len - 1'b1);
    // Masked outside TX so a partly shifted frame never shows on the line.
    assign data = en && sr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= load_data;
            cnt <= '0;
        end else if (hs) begin
            sr  <= {1'b0, sr[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/puf_seq_ctrl.sv
// Arbiter-PUF sequencer: serial challenge in, one launch, serial frame out.
// Optional evaluation watchdog enabled by defining PUF_SEQ_CTRL_WDOG_EN.
module puf_seq_ctrl
    import puf_soc_pkg::*;
#(
    parameter int unsigned REG_BIT_SIZE = DEF_REG_BIT_SIZE,
    parameter int unsigned NORM_MOD     = DEF_NORM_MOD,
    parameter int unsigned DEBUG_MOD    = DEF_DEBUG_MOD,
    parameter int unsigned CNT_BIT_SIZE = DEF_CNT_BIT_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic                          i_op_mode,
    output logic                          o_rx_ready,
    input  logic                          i_rx_valid,
    input  logic                          i_rx_data,
    output logic [REG_BIT_SIZE-1:0]       o_chal,
    output logic                          o_puf_launch,
    input  logic                          i_puf_done,
    input  logic [NORM_MOD-1:0]           i_puf_resp,
    input  logic [DEBUG_MOD-NORM_MOD-1:0] i_dbg_data,
    input  logic                          i_tx_ready,
    output logic                          o_tx_valid,
    output logic                          o_tx_data,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err
);

    localparam int unsigned CNT_W = $clog2(DEBUG_MOD + 1);

    if (DEBUG_MOD <= NORM_MOD || CNT_BIT_SIZE < 2) begin : g_bad_params
        $error("puf_seq_ctrl: DEBUG_MOD must exceed NORM_MOD and CNT_BIT_SIZE must be at least 2");
    end

    puf_seq_state_e          state, state_nxt;
    logic [REG_BIT_SIZE-1:0] chal;
    logic [CNT_W-1:0]        rx_cnt;
    logic                    op_mode;
    logic                    done_q;
    logic                    start_acc;
    logic                    rx_hs;
    logic                    rx_last;
    logic                    frame_load;
    logic                    tx_last;
    logic                    wdog_expire;
    logic [CNT_W-1:0]        tx_len;

    assign start_acc  = (state == ST_IDLE) && i_start;
    assign rx_hs      = (state == ST_RX_CHAL) && i_rx_valid;
    assign rx_last    = rx_hs && (rx_cnt == CNT_W'(REG_BIT_SIZE - 1));
    assign frame_load = (state == ST_WAIT) && i_puf_done;
    assign tx_len     = CNT_W'(frame_len(op_mode, NORM_MOD, DEBUG_MOD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (i_start) state_nxt = ST_RX_CHAL;
            ST_RX_CHAL: if (rx_last) state_nxt = ST_LAUNCH;
            ST_LAUNCH:  state_nxt = ST_WAIT;
            // A completion in the expiry cycle takes priority over the timeout.
            ST_WAIT: begin
                if (i_puf_done) begin
                    state_nxt = ST_TX;
                end else if (wdog_expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TX:      if (tx_last) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chal    <= '0;
            rx_cnt  <= '0;
            op_mode <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= tx_last;
            if (start_acc) begin
                op_mode <= i_op_mode;
                rx_cnt  <= '0;
            end else if (rx_hs) begin
                chal   <= {i_rx_data, chal[REG_BIT_SIZE-1:1]};
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

`ifdef PUF_SEQ_CTRL_WDOG_EN
    localparam logic [CNT_BIT_SIZE-1:0] WDOG_LAST = {{(CNT_BIT_SIZE - 1){1'b1}}, 1'b0};

    logic [CNT_BIT_SIZE-1:0] wdog_cnt;
    logic                    err_q;

    // Expiry is flagged on the edge that would bring the count to all-ones.
    assign wdog_expire = (state == ST_WAIT) && (wdog_cnt == WDOG_LAST);
    assign o_err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_WAIT) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end else begin
                wdog_cnt <= '0;
            end
            if (start_acc) begin
                err_q <= 1'b0;
            end else if (wdog_expire && !i_puf_done) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign wdog_expire = 1'b0;
    assign o_err       = 1'b0;
`endif

    puf_seq_piso #(
        .WIDTH (DEBUG_MOD),
        .CNT_W (CNT_W)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (frame_load),
        .load_data ({i_dbg_data, i_puf_resp}),
        .len       (tx_len),
        .en        (state == ST_TX),
        .ready     (i_tx_ready),
        .data      (o_tx_data),
        .last      (tx_last)
    );

    assign o_rx_ready   = (state == ST_RX_CHAL);
    assign o_puf_launch = (state == ST_LAUNCH);
    assign o_tx_valid   = (state == ST_TX);
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = done_q;
    assign o_chal       = chal;

endmodule

// File: tb/tb_puf_seq_ctrl.sv
// Directed, table-driven bench for puf_seq_ctrl; watchdog sequences follow
// PUF_SEQ_CTRL_WDOG_EN.
module tb_puf_seq_ctrl;

    localparam int unsigned RB = 8;
    localparam int unsigned NM = 34;
    localparam int unsigned DM = 133;
    localparam int unsigned DW = DM - NM;
    localparam int unsigned CB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_op_mode, i_rx_valid, i_rx_data;
    logic          i_puf_done, i_tx_ready;
    logic [NM-1:0] i_puf_resp;
    logic [DW-1:0] i_dbg_data;
    logic          o_rx_ready, o_puf_launch, o_tx_valid, o_tx_data;
    logic          o_busy, o_done, o_err;
    logic [RB-1:0] o_chal;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    puf_seq_ctrl #(
        .REG_BIT_SIZE (RB),
        .NORM_MOD     (NM),
        .DEBUG_MOD    (DM),
        .CNT_BIT_SIZE (CB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_op_mode    (i_op_mode),
        .o_rx_ready   (o_rx_ready),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_chal       (o_chal),
        .o_puf_launch (o_puf_launch),
        .i_puf_done   (i_puf_done),
        .i_puf_resp   (i_puf_resp),
        .i_dbg_data   (i_dbg_data),
        .i_tx_ready   (i_tx_ready),
        .o_tx_valid   (o_tx_valid),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    typedef struct {
        logic          op;
        logic [7:0]    seq;       // first bit sent is seq[7]
        logic [7:0]    exp_chal;
        logic [NM-1:0] resp;
        logic [DW-1:0] dbg;
        logic [3:0]    rdy;       // ready pattern, rdy[3] applied first
        bit            gap;
        bit            hold;
        bit            poke;
        int unsigned   abort_bit;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [DM-1:0] act, input logic [DM-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input logic op);
        i_start   = 1'b1;
        i_op_mode = op;
        tick();
        i_start   = 1'b0;
        i_op_mode = ~op;
        check("start_rx_ready", o_rx_ready, 1);
        check("start_busy", o_busy, 1);
        check("start_err_clear", o_err, 0);
    endtask

    task automatic send_chal(input logic [7:0] seq, input bit gap, input bit hold,
                             input logic [7:0] exp_chal);
        for (int b = 0; b < RB; b++) begin
            if (gap) begin
                i_rx_valid = 1'b0;
                i_rx_data  = 1'b1;
                tick();
            end
            i_rx_valid = 1'b1;
            i_rx_data  = seq[RB-1-b];
            tick();
        end
        if (!hold) i_rx_valid = 1'b0;
        i_rx_data = 1'b1;
        check("launch_pulse", o_puf_launch, 1);
        check("rx_ready_off", o_rx_ready, 0);
        tick();
        check("launch_single", o_puf_launch, 0);
        check("chal_value", o_chal, exp_chal);
    endtask

    task automatic finish_wait(input int unsigned n, input bit poke, input logic [NM-1:0] resp,
                               input logic [DW-1:0] dbg, input logic [7:0] exp_chal);
        for (int i = 0; i < n; i++) begin
            if (poke && i == 0) i_start = 1'b1;
            i_rx_data = ~i_rx_data;
            tick();
            i_start = 1'b0;
        end
        check("wait_busy", o_busy, 1);
        check("wait_no_tx", o_tx_valid, 0);
        check("wait_no_rx", o_rx_ready, 0);
        i_puf_done = 1'b1;
        i_puf_resp = resp;
        i_dbg_data = dbg;
        tick();
        i_puf_done = 1'b0;
        i_puf_resp = ~resp;
        i_dbg_data = ~dbg;
        i_rx_valid = 1'b0;
        check("tx_start", o_tx_valid, 1);
        check("chal_hold", o_chal, exp_chal);
        check("err_low", o_err, 0);
    endtask

    task automatic drain_tx(input logic op, input logic [NM-1:0] resp, input logic [DW-1:0] dbg,
                            input logic [3:0] pat, input int unsigned abort_bit);
        logic [DM-1:0] got, expf;
        int unsigned   len, idx, cyc;
        bit            stall_bad, valid_bad, early_done, prev_stall;
        logic          prev;
        len = op ? DM : NM;
        expf = {dbg, resp};
        if (!op) begin
            for (int i = NM; i < DM; i++) expf[i] = 1'b0;
        end
        got = '0;
        idx = 0;
        cyc = 0;
        stall_bad = 0;
        valid_bad = 0;
        early_done = 0;
        prev_stall = 0;
        prev = 1'b0;
        while (idx < len && cyc < 2000) begin
            if (abort_bit != 0 && idx == abort_bit - 1) begin
                rst = 1'b1;
                #1;
                check("rst_outputs", {o_rx_ready, o_puf_launch, o_tx_valid, o_tx_data,
                                      o_busy, o_done, o_err}, 0);
                check("rst_chal", o_chal, 0);
                i_tx_ready = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (prev_stall && o_tx_data !== prev) stall_bad = 1;
            if (o_tx_valid !== 1'b1) valid_bad = 1;
            if (o_done) early_done = 1;
            i_tx_ready = pat[3 - (cyc % 4)];
            if (i_tx_ready) got[idx] = o_tx_data;
            prev_stall = !i_tx_ready;
            prev = o_tx_data;
            if (i_tx_ready) idx++;
            cyc++;
            tick();
        end
        i_tx_ready = 1'b0;
        check("tx_in_budget", idx, len);
        check("tx_frame", got, expf);
        check("tx_valid_held", valid_bad, 0);
        check("tx_stall_stable", stall_bad, 0);
        check("no_early_done", early_done, 0);
        check("done_pulse", o_done, 1);
        check("busy_fall", o_busy, 0);
        check("tx_valid_off", o_tx_valid, 0);
        tick();
        check("done_one_cycle", o_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n;
        bit seen_done;

        vecs[0] = '{1'b0, 8'b1011_0010, 8'h4D, 34'h2_DEAD_BEEF, {DW{1'b1}}, 4'b1111, 1'b0, 1'b0, 1'b0, 10};
        vecs[1] = '{1'b0, 8'b1011_0010, 8'h4D, 34'h2_DEAD_BEEF, {DW{1'b1}}, 4'b1111, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 8'b0000_0001, 8'h80, 34'h0,           {DW{1'b1}}, 4'b1111, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b0, 8'b1111_0000, 8'h0F, 34'h1_2345_6789, {DW{1'b1}}, 4'b1001, 1'b0, 1'b1, 1'b1, 0};
        vecs[4] = '{1'b1, 8'b0101_0101, 8'hAA, 34'h3_0F0F_A5A5,
                    99'h5A5A50F0F123456789ABCDEF0, 4'b1001, 1'b1, 1'b0, 1'b0, 0};

        rst = 1'b1;
        i_start = 1'b0;
        i_op_mode = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data = 1'b0;
        i_puf_done = 1'b0;
        i_tx_ready = 1'b0;
        i_puf_resp = '0;
        i_dbg_data = '0;
        #12;
        check("reset_outputs", {o_rx_ready, o_puf_launch, o_tx_valid, o_tx_data,
                                o_busy, o_done, o_err}, 0);
        check("reset_chal", o_chal, 0);
        rst = 1'b0;
        tick();
        check("idle_not_busy", o_busy, 0);

        for (int v = 0; v < 5; v++) begin
            start_txn(vecs[v].op);
            send_chal(vecs[v].seq, vecs[v].gap, vecs[v].hold, vecs[v].exp_chal);
            finish_wait(3, vecs[v].poke, vecs[v].resp, vecs[v].dbg, vecs[v].exp_chal);
            drain_tx(vecs[v].op, vecs[v].resp, vecs[v].dbg, vecs[v].rdy, vecs[v].abort_bit);
            tick();
        end

`ifdef PUF_SEQ_CTRL_WDOG_EN
        start_txn(1'b0);
        send_chal(8'b1000_0000, 1'b0, 1'b0, 8'h01);
        n = 0;
        seen_done = 0;
        while (o_busy && n < 100) begin
            n++;
            if (o_done) seen_done = 1;
            tick();
        end
        check("wdog_wait_cycles", n, 31);
        check("wdog_err_set", o_err, 1);
        check("wdog_no_done", seen_done || o_done, 0);
        check("wdog_no_tx", o_tx_valid, 0);
        tick();
        check("wdog_err_sticky", o_err, 1);
        start_txn(1'b0);
        send_chal(8'b1000_0000, 1'b0, 1'b0, 8'h01);
        finish_wait(30, 1'b0, 34'h1_5555_AAAA, {DW{1'b0}}, 8'h01);
        drain_tx(1'b0, 34'h1_5555_AAAA, {DW{1'b0}}, 4'b1111, 0);
`else
        start_txn(1'b1);
        send_chal(8'b1000_0000, 1'b0, 1'b0, 8'h01);
        finish_wait(40, 1'b0, 34'h1_5555_AAAA, {DW{1'b0}}, 8'h01);
        drain_tx(1'b1, 34'h1_5555_AAAA, {DW{1'b0}}, 4'b1111, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
